// File: rtl/serial_add_sub.sv
// Digit-serial WIDTH-bit adder/subtractor: one DIGIT-bit slice per cycle, LSB first, start/done handshake.
// Define SERIAL_ADD_SUB_SUB_EN to honour ctrl (subtract); otherwise the unit only adds.
module serial_add_sub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_add_sub: WIDTH must be a positive multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] areg;
  logic [WIDTH-1:0] breg;
  logic [WIDTH-1:0] zacc;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] bin;
  logic             cin;

`ifdef SERIAL_ADD_SUB_SUB_EN
  // Subtract as a + ~b + 1: invert b once at load and seed the carry with ctrl.
  assign bin = b ^ {WIDTH{ctrl}};
  assign cin = ctrl;
`else
  logic ctrl_unused;
  assign ctrl_unused = ctrl;
  assign bin = b;
  assign cin = 1'b0;
`endif

  logic [31:0]      base;
  logic [DIGIT-1:0] as_s;
  logic [DIGIT-1:0] bs_s;
  logic [DIGIT:0]   sum;
  logic             cmsb;
  logic             last;
  logic [WIDTH-1:0] znext;

  always_comb begin
    base  = 32'(cnt) * 32'(DIGIT);
    as_s  = areg[base +: DIGIT];
    bs_s  = breg[base +: DIGIT];
    sum   = {1'b0, as_s} + {1'b0, bs_s} + {{DIGIT{1'b0}}, carry};
    // Carry into the slice's top bit recovered from its sum bit; on the last slice this is the MSB carry-in.
    cmsb  = sum[DIGIT-1] ^ as_s[DIGIT-1] ^ bs_s[DIGIT-1];
    last  = (cnt == CW'(N - 1));
    znext = zacc;
    znext[base +: DIGIT] = sum[DIGIT-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      areg  <= '0;
      breg  <= '0;
      zacc  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      z     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            areg  <= a;
            breg  <= bin;
            carry <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          zacc  <= znext;
          carry <= sum[DIGIT];
          cnt   <= cnt + 1'b1;
          if (last) begin
            z     <= znext;
            cout  <= sum[DIGIT];
            ovf   <= sum[DIGIT] ^ cmsb;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub: default 8/1 instance plus 8/4, 4/2 and 4/4 variants.
module tb_serial_add_sub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       ctrl;
  logic [7:0] a8, b8;
  logic [3:0] a4, b4;
  logic       st8, st84, st42, st44;

  logic       busy8, d8, c8, o8;
  logic [7:0] z8;
  logic       busy84, d84, c84, o84;
  logic [7:0] z84;
  logic       busy42, d42, c42, o42;
  logic [3:0] z42;
  logic       busy44, d44, c44, o44;
  logic [3:0] z44;

  int total = 0;
  int bad   = 0;

  serial_add_sub #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .reset(reset), .start(st8), .ctrl(ctrl), .a(a8), .b(b8),
    .busy(busy8), .done(d8), .z(z8), .cout(c8), .ovf(o8));

  serial_add_sub #(.WIDTH(8), .DIGIT(4)) dut84 (
    .clk(clk), .reset(reset), .start(st84), .ctrl(ctrl), .a(a8), .b(b8),
    .busy(busy84), .done(d84), .z(z84), .cout(c84), .ovf(o84));

  serial_add_sub #(.WIDTH(4), .DIGIT(2)) dut42 (
    .clk(clk), .reset(reset), .start(st42), .ctrl(ctrl), .a(a4), .b(b4),
    .busy(busy42), .done(d42), .z(z42), .cout(c42), .ovf(o42));

  serial_add_sub #(.WIDTH(4), .DIGIT(4)) dut44 (
    .clk(clk), .reset(reset), .start(st44), .ctrl(ctrl), .a(a4), .b(b4),
    .busy(busy44), .done(d44), .z(z44), .cout(c44), .ovf(o44));

  function automatic logic done_of(input int w);
    case (w)
      0:       return d8;
      1:       return d84;
      2:       return d42;
      default: return d44;
    endcase
  endfunction

  // Start one operation on instance w and wait (bounded) for done; lat = edges after acceptance, -1 on timeout.
  task automatic run_op(input int w, input logic [7:0] av, input logic [7:0] bv, input logic cv,
                        output int lat);
    logic got;
    ctrl = cv;
    if (w < 2) begin a8 = av; b8 = bv; end
    else begin a4 = av[3:0]; b4 = bv[3:0]; end
    case (w)
      0: st8 = 1'b1;
      1: st84 = 1'b1;
      2: st42 = 1'b1;
      default: st44 = 1'b1;
    endcase
    @(posedge clk); #1;
    st8 = 1'b0; st84 = 1'b0; st42 = 1'b0; st44 = 1'b0;
    got = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(posedge clk); #1;
      if (done_of(w)) begin got = 1'b1; lat = i; end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy8, d8, z8, c8, o8} !== 12'h000) begin
      bad++;
      $display("FAIL reset8 got busy=%b done=%b z=%h cout=%b ovf=%b want all 0", busy8, d8, z8, c8, o8);
    end
    total++;
    if ({busy84, d84, z84, c84, o84, busy42, d42, z42, c42, o42, busy44, d44, z44, c44, o44} !== '0) begin
      bad++;
      $display("FAIL reset_variants got z84=%h z42=%h z44=%h busy=%b%b%b want all 0",
               z84, z42, z44, busy84, busy42, busy44);
    end
    reset = 1'b0;
  endtask

  task automatic test_add;
    logic ok;
    a8 = 8'h7F; b8 = 8'h01; ctrl = 1'b0; st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0;
    total++;
    if ({busy8, d8} !== 2'b10) begin
      bad++;
      $display("FAIL add_accept got busy=%b done=%b want busy=1 done=0", busy8, d8);
    end
    ok = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk); #1;
      if ({busy8, d8, z8} !== {2'b10, 8'h00}) ok = 1'b0;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL add_run got busy=%b done=%b z=%h want busy=1 done=0 z=00 throughout", busy8, d8, z8);
    end
    @(posedge clk); #1;
    total++;
    if ({d8, busy8, z8, c8, o8} !== {2'b10, 8'h80, 2'b01}) begin
      bad++;
      $display("FAIL add_done got done=%b busy=%b z=%h cout=%b ovf=%b want 1 0 80 0 1", d8, busy8, z8, c8, o8);
    end
    @(posedge clk); #1;
    total++;
    if ({d8, busy8, z8} !== {2'b00, 8'h80}) begin
      bad++;
      $display("FAIL add_pulse got done=%b busy=%b z=%h want 0 0 80", d8, busy8, z8);
    end
  endtask

  task automatic test_sub;
    int lat;
    logic [10:0] e1, e2;
`ifdef SERIAL_ADD_SUB_SUB_EN
    e1 = {8'hFE, 1'b0, 1'b0, 1'b0};
    e2 = {8'h7F, 1'b1, 1'b1, 1'b0};
`else
    e1 = {8'h0C, 1'b0, 1'b0, 1'b0};
    e2 = {8'h81, 1'b0, 1'b0, 1'b0};
`endif
    run_op(0, 8'h05, 8'h07, 1'b1, lat);
    total++;
    if ({z8, c8, o8, 1'b0} !== e1 || lat != 8) begin
      bad++;
      $display("FAIL sub_5_7 got z=%h cout=%b ovf=%b lat=%0d want z=%h cout=%b ovf=%b lat=8",
               z8, c8, o8, lat, e1[10:3], e1[2], e1[1]);
    end
    run_op(0, 8'h80, 8'h01, 1'b1, lat);
    total++;
    if ({z8, c8, o8, 1'b0} !== e2 || lat != 8) begin
      bad++;
      $display("FAIL sub_80_1 got z=%h cout=%b ovf=%b lat=%0d want z=%h cout=%b ovf=%b lat=8",
               z8, c8, o8, lat, e2[10:3], e2[2], e2[1]);
    end
  endtask

  task automatic test_busy_ignore;
    int ndone, at;
    logic held;
    logic [7:0] zprev;
`ifdef SERIAL_ADD_SUB_SUB_EN
    zprev = 8'h7F;
`else
    zprev = 8'h81;
`endif
    a8 = 8'h03; b8 = 8'h04; ctrl = 1'b0; st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0;
    ndone = 0; at = 0; held = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      if (i == 3) begin st8 = 1'b1; a8 = 8'hFF; end
      @(posedge clk); #1;
      st8 = 1'b0;
      if (d8) begin ndone++; at = i; end
      else if (at == 0 && z8 !== zprev) held = 1'b0;
    end
    total++;
    if (ndone != 1 || at != 8 || z8 !== 8'h07) begin
      bad++;
      $display("FAIL busy_ignore got dones=%0d at=%0d z=%h want 1 at 8 z=07", ndone, at, z8);
    end
    total++;
    if (!held) begin
      bad++;
      $display("FAIL busy_hold got z=%h before done want %h", z8, zprev);
    end
  endtask

  task automatic test_back_to_back;
    a8 = 8'h10; b8 = 8'h20; ctrl = 1'b0; st8 = 1'b1;
    @(posedge clk); #1;
    a8 = 8'h01; b8 = 8'h02;
    repeat (8) @(posedge clk);
    #1;
    total++;
    if ({d8, busy8, z8} !== {2'b10, 8'h30}) begin
      bad++;
      $display("FAIL b2b_first got done=%b busy=%b z=%h want 1 0 30", d8, busy8, z8);
    end
    @(posedge clk); #1;
    st8 = 1'b0;
    total++;
    if ({d8, busy8, z8} !== {2'b01, 8'h30}) begin
      bad++;
      $display("FAIL b2b_restart got done=%b busy=%b z=%h want 0 1 30", d8, busy8, z8);
    end
    repeat (8) @(posedge clk);
    #1;
    total++;
    if ({d8, busy8, z8} !== {2'b10, 8'h03}) begin
      bad++;
      $display("FAIL b2b_second got done=%b busy=%b z=%h want 1 0 03", d8, busy8, z8);
    end
    @(posedge clk); #1;
    total++;
    if ({d8, busy8} !== 2'b00) begin
      bad++;
      $display("FAIL b2b_idle got done=%b busy=%b want 0 0", d8, busy8);
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    a8 = 8'h55; b8 = 8'h11; ctrl = 1'b0; st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    total++;
    if ({busy8, d8, z8, c8, o8} !== 12'h000) begin
      bad++;
      $display("FAIL reset_mid got busy=%b done=%b z=%h cout=%b ovf=%b want all 0", busy8, d8, z8, c8, o8);
    end
    #1;
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (d8 || busy8) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL reset_abort got %0d cycles with done/busy want 0", seen);
    end
  endtask

  task automatic test_digit4;
    int lat;
    run_op(1, 8'hFF, 8'h01, 1'b0, lat);
    total++;
    if (lat != 2 || {z84, c84, o84} !== {8'h00, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL digit4 got lat=%0d z=%h cout=%b ovf=%b want lat=2 z=00 cout=1 ovf=0", lat, z84, c84, o84);
    end
    run_op(3, 8'h07, 8'h01, 1'b0, lat);
    total++;
    if (lat != 1 || {z44, c44, o44} !== {4'h8, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL width_eq_digit got lat=%0d z=%h cout=%b ovf=%b want lat=1 z=8 cout=0 ovf=1", lat, z44, c44, o44);
    end
  endtask

  task automatic test_exhaustive;
    int lat;
    logic ce;
    logic [4:0] r;
    logic [3:0] ez;
    logic ec, eo;
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        for (int c = 0; c < 2; c++) begin
          run_op(2, 8'(x), 8'(y), c[0], lat);
`ifdef SERIAL_ADD_SUB_SUB_EN
          ce = c[0];
`else
          ce = 1'b0;
`endif
          if (ce) begin
            ez = 4'(x - y);
            ec = (x >= y);
            eo = (x[3] != y[3]) && (ez[3] != x[3]);
          end else begin
            r  = 5'(x + y);
            ez = r[3:0];
            ec = r[4];
            eo = (x[3] == y[3]) && (ez[3] != x[3]);
          end
          total++;
          if (lat != 2 || {c42, z42, o42} !== {ec, ez, eo}) begin
            bad++;
            $display("FAIL exh a=%h b=%h ctrl=%0d got lat=%0d cout=%b z=%h ovf=%b want lat=2 cout=%b z=%h ovf=%b",
                     x, y, c, lat, c42, z42, o42, ec, ez, eo);
          end
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; ctrl = 1'b0;
    a8 = '0; b8 = '0; a4 = '0; b4 = '0;
    st8 = 1'b0; st84 = 1'b0; st42 = 1'b0; st44 = 1'b0;
    test_reset;
    @(posedge clk); #1;
    test_add;
    test_sub;
    test_busy_ignore;
    test_back_to_back;
    test_reset_mid;
    test_digit4;
    test_exhaustive;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
